// File: rtl/xor_decrypt_rx_pkg.sv
// Shared defaults, FSM state encoding and counter sizing for the XOR decrypt receiver.
package xor_decrypt_rx_pkg;

    localparam int MSG_SIZE_DEF = 64;
    localparam int KEY_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DECRYPT = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    // One spare bit so a counter can hold the full size without wrapping.
    function automatic int cnt_width(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/xor_decrypt_rx_if.sv
// Serial key/ciphertext input and plaintext output lines of the XOR decrypt receiver.
interface xor_decrypt_rx_if;

    // Flag semantics: iKey_flag / iCt_flag qualify iData_in on the cycle they are
    // high (no backpressure, no ready); oData_flag qualifies oData_out the same way.
    logic iData_in;
    logic iKey_flag;
    logic iCt_flag;
    logic oData_out;
    logic oData_flag;
    logic oDecrypt_status;
    logic oBusy;

    modport master (
        output iData_in, iKey_flag, iCt_flag,
        input  oData_out, oData_flag, oDecrypt_status, oBusy
    );

    modport slave (
        input  iData_in, iKey_flag, iCt_flag,
        output oData_out, oData_flag, oDecrypt_status, oBusy
    );

endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: emits WIDTH bits MSB first with a qualifying flag.
module piso_shift #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out,
    output logic             flag,
    output logic             last
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (ena) begin
            if (load) begin
                shreg_q <= par_in;
                cnt_q   <= CW'(WIDTH);
            end else if (cnt_q != '0) begin
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                cnt_q   <= cnt_q - CW'(1);
            end
        end
    end

    assign flag    = (cnt_q != '0);
    assign ser_out = flag & shreg_q[WIDTH-1];
    assign last    = (cnt_q == CW'(1));

endmodule

// File: rtl/xor_decrypt_rx.sv
// Serial XOR decryptor: collects key and ciphertext bits, XORs them with a
// repeating key and streams the plaintext back out MSB first.
module xor_decrypt_rx
    import xor_decrypt_rx_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int KEY_SIZE = KEY_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    xor_decrypt_rx_if.slave bus,
    output state_t          dbg_state
);
    localparam int KW = cnt_width(KEY_SIZE);
    localparam int CW = cnt_width(MSG_SIZE);
    localparam logic [KW-1:0] KEY_FULL = KW'(KEY_SIZE);
    localparam logic [CW-1:0] CT_FULL  = CW'(MSG_SIZE);

    state_t              state_q, state_d;
    logic [KEY_SIZE-1:0] key_q;
    logic [KW-1:0]       key_cnt_q;
    logic                key_flag_q;
    logic [MSG_SIZE-1:0] ct_q;
    logic [CW-1:0]       ct_cnt_q;
    logic [MSG_SIZE-1:0] pt_calc;
    logic [MSG_SIZE-1:0] pt_q;

    logic key_full, ct_full, key_restart, key_take, ct_take;
    logic send_last, send_flag, send_bit;

    assign key_full    = (key_cnt_q == KEY_FULL);
    assign ct_full     = (ct_cnt_q == CT_FULL);
    // A fresh rising key flag after a complete key starts a new key with this bit.
    assign key_restart = bus.iKey_flag && !key_flag_q && key_full;
    assign key_take    = bus.iKey_flag && (!key_full || key_restart);
    assign ct_take     = bus.iCt_flag && !ct_full &&
                         ((state_q == ST_IDLE) || (state_q == ST_LOAD));

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= '0;
            key_cnt_q  <= '0;
            key_flag_q <= 1'b0;
        end else if (ena) begin
            key_flag_q <= bus.iKey_flag;
            if (key_take) begin
                key_q     <= {key_q[KEY_SIZE-2:0], bus.iData_in};
                key_cnt_q <= key_restart ? KW'(1) : key_cnt_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_q     <= '0;
            ct_cnt_q <= '0;
        end else if (ena) begin
            if ((state_q == ST_SEND) && send_last) begin
                ct_cnt_q <= '0;
            end else if (ct_take) begin
                ct_q     <= {ct_q[MSG_SIZE-2:0], bus.iData_in};
                ct_cnt_q <= ct_cnt_q + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < MSG_SIZE; i++) begin : g_xor
        assign pt_calc[i] = ct_q[i] ^ key_q[i % KEY_SIZE];
    end

    // Plaintext is captured on entry to DECRYPT so later key loads cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pt_q <= '0;
        end else if (ena && (state_q == ST_LOAD) && (state_d == ST_DECRYPT)) begin
            pt_q <= pt_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.oDecrypt_status = 1'b0;
        bus.oBusy           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iCt_flag) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (ct_full && key_full) state_d = ST_DECRYPT;
            end
            ST_DECRYPT: begin
                bus.oDecrypt_status = 1'b1;
                bus.oBusy           = 1'b1;
                state_d             = ST_SEND;
            end
            ST_SEND: begin
                bus.oBusy = 1'b1;
                if (send_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    piso_shift #(
        .WIDTH (MSG_SIZE)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .load    (state_q == ST_DECRYPT),
        .par_in  (pt_q),
        .ser_out (send_bit),
        .flag    (send_flag),
        .last    (send_last)
    );

    assign bus.oData_out  = send_bit;
    assign bus.oData_flag = send_flag;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_xor_decrypt_rx.sv
// Directed and randomized bench for xor_decrypt_rx against a plaintext reference model.
module tb_xor_decrypt_rx;
    import xor_decrypt_rx_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   ena = 1'b1;
    state_t dbg_state;

    xor_decrypt_rx_if bus ();

    xor_decrypt_rx #(
        .MSG_SIZE (64),
        .KEY_SIZE (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;
    int          first_cyc  = 0;
    int          status_cnt = 0;
    int          zero_bad   = 0;
    bit          rec        = 1'b1;
    logic        got_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] ref_pt(input logic [63:0] ct, input logic [7:0] k);
        return ct ^ {8{k}};
    endfunction

    function automatic logic [63:0] got_val();
        logic [63:0] v = '0;
        foreach (got_q[i]) v = {v[62:0], got_q[i]};
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.oData_flag) begin
            if (rec) begin
                if (got_q.size() == 0) first_cyc = cyc;
                got_q.push_back(bus.oData_out);
            end
        end else if (bus.oData_out !== 1'b0) begin
            zero_bad++;
        end
        if (bus.oDecrypt_status && rec) status_cnt++;
    endtask

    task automatic clear_rx();
        got_q.delete();
        status_cnt = 0;
        first_cyc  = 0;
    endtask

    task automatic send_key(input logic [7:0] k);
        for (int i = 7; i >= 0; i--) begin
            bus.iKey_flag = 1'b1;
            bus.iData_in  = k[i];
            tick();
        end
        bus.iKey_flag = 1'b0;
        bus.iData_in  = 1'b0;
    endtask

    task automatic send_ct(input logic [63:0] ct, input int gap_at, input int gap_len,
                           output int last_cyc);
        for (int i = 63; i >= 0; i--) begin
            if (63 - i == gap_at) begin
                bus.iCt_flag = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    bus.iData_in = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            bus.iCt_flag = 1'b1;
            bus.iData_in = ct[i];
            tick();
        end
        last_cyc     = cyc;
        bus.iCt_flag = 1'b0;
        bus.iData_in = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        int k = 0;
        while (got_q.size() < n && k < 300) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_msg(input string tag);
        int k = 0;
        while (!(got_q.size() >= 64 && !bus.oData_flag) && k < 400) begin
            tick();
            k++;
        end
        check({tag, "_bitcount"}, 64'(got_q.size()), 64'd64);
    endtask

    task automatic check_msg(input string tag);
        logic [63:0] e;
        e = exp_q.pop_front();
        check({tag, "_plaintext"}, got_val(), e);
    endtask

    initial begin
        int          last_cyc;
        int          key_done;
        int          frz_bad;
        logic        held;
        logic [63:0] ct;
        logic [63:0] ct2;
        logic [7:0]  k;
        logic [7:0]  k2;

        bus.iData_in  = 1'b0;
        bus.iKey_flag = 1'b0;
        bus.iCt_flag  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_flag",   64'(bus.oData_flag), 64'd0);
        check("rst_out",    64'(bus.oData_out), 64'd0);
        check("rst_status", 64'(bus.oDecrypt_status), 64'd0);
        check("rst_busy",   64'(bus.oBusy), 64'd0);
        check("rst_state",  64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Known-answer vector, latency and status pulse
        clear_rx();
        send_key(8'hA5);
        exp_q.push_back(64'hA486E0C22C0E684A);
        send_ct(64'h0123456789ABCDEF, -1, 0, last_cyc);
        wait_msg("kat");
        check_msg("kat");
        check("kat_latency", 64'(first_cyc), 64'(last_cyc + 2));
        check("kat_status_pulses", 64'(status_cnt), 64'd1);
        check("kat_busy_after", 64'(bus.oBusy), 64'd0);
        check("kat_state_after", 64'(dbg_state), 64'(ST_IDLE));

        // Zero key passes ciphertext through
        clear_rx();
        send_key(8'h00);
        exp_q.push_back(64'hFFFF0000AAAA5555);
        send_ct(64'hFFFF0000AAAA5555, -1, 0, last_cyc);
        wait_msg("zkey");
        check_msg("zkey");

        // Ciphertext before key: waits in LOAD, ignores extra ct bits
        rst = 1'b1; tick(); rst = 1'b0; tick();
        clear_rx();
        ct = {$urandom(), $urandom()};
        exp_q.push_back(ref_pt(ct, 8'h3C));
        send_ct(ct, -1, 0, last_cyc);
        for (int i = 0; i < 10; i++) begin
            bus.iCt_flag = 1'b1;
            bus.iData_in = 1'($urandom_range(0, 1));
            tick();
        end
        bus.iCt_flag = 1'b0;
        tick();
        check("late_key_state", 64'(dbg_state), 64'(ST_LOAD));
        check("late_key_busy", 64'(bus.oBusy), 64'd0);
        send_key(8'h3C);
        key_done = cyc;
        check("late_key_no_early_out", 64'(got_q.size() + status_cnt), 64'd0);
        wait_msg("late_key");
        check_msg("late_key");
        check("late_key_latency", 64'(first_cyc), 64'(key_done + 2));

        // Ciphertext flag dropped for 5 cycles after 20 bits
        clear_rx();
        k  = 8'($urandom_range(0, 255));
        ct = {$urandom(), $urandom()};
        send_key(k);
        exp_q.push_back(ref_pt(ct, k));
        send_ct(ct, 20, 5, last_cyc);
        wait_msg("gap");
        check_msg("gap");
        check("gap_latency", 64'(first_cyc), 64'(last_cyc + 2));

        // Reset at SEND bit 30, then a fresh message
        clear_rx();
        k  = 8'($urandom_range(0, 255));
        ct = {$urandom(), $urandom()};
        send_key(k);
        send_ct(ct, -1, 0, last_cyc);
        wait_bits(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_flag", 64'(bus.oData_flag), 64'd0);
        check("abort_busy", 64'(bus.oBusy), 64'd0);
        repeat (5) tick();
        check("abort_no_more_bits", 64'(got_q.size()), 64'd30);
        clear_rx();
        k2  = 8'($urandom_range(0, 255));
        ct2 = {$urandom(), $urandom()};
        send_key(k2);
        exp_q.push_back(ref_pt(ct2, k2));
        send_ct(ct2, -1, 0, last_cyc);
        wait_msg("after_abort");
        check_msg("after_abort");

        // Enable low for 10 cycles mid-SEND
        clear_rx();
        k  = 8'($urandom_range(0, 255));
        ct = {$urandom(), $urandom()};
        send_key(k);
        exp_q.push_back(ref_pt(ct, k));
        send_ct(ct, -1, 0, last_cyc);
        wait_bits(20);
        held    = bus.oData_out;
        frz_bad = 0;
        ena     = 1'b0;
        rec     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.oData_out !== held || bus.oData_flag !== 1'b1 || bus.oBusy !== 1'b1)
                frz_bad++;
        end
        ena = 1'b1;
        rec = 1'b1;
        check("freeze_hold", 64'(frz_bad), 64'd0);
        wait_msg("freeze");
        check_msg("freeze");

        // Both flags high share bits; key reload and ct bits during SEND
        rst = 1'b1; tick(); rst = 1'b0; tick();
        clear_rx();
        ct = {$urandom(), $urandom()};
        exp_q.push_back(ref_pt(ct, ct[63:56]));
        for (int i = 63; i >= 0; i--) begin
            bus.iCt_flag  = 1'b1;
            bus.iKey_flag = (i >= 56);
            bus.iData_in  = ct[i];
            tick();
        end
        bus.iCt_flag  = 1'b0;
        bus.iKey_flag = 1'b0;
        wait_bits(5);
        k2 = 8'($urandom_range(0, 255));
        send_key(k2);
        for (int i = 0; i < 4; i++) begin
            bus.iCt_flag = 1'b1;
            bus.iData_in = 1'($urandom_range(0, 1));
            tick();
        end
        bus.iCt_flag = 1'b0;
        wait_msg("shared");
        check_msg("shared");
        clear_rx();
        ct2 = {$urandom(), $urandom()};
        exp_q.push_back(ref_pt(ct2, k2));
        send_ct(ct2, -1, 0, last_cyc);
        wait_msg("rekey");
        check_msg("rekey");

        check("out_zero_without_flag", 64'(zero_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
